// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent divided outputs from one
// source clock, with shadowed divisor updates at period boundaries and a common resync.

module clock_div_ch #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             in,
    input  logic             resetb,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             sync_all,
    output logic             out,
    output logic             rise,
    output logic             pending
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic [WIDTH-1:0] eff;
    logic [WIDTH:0]   half;
    logic             wrap;

    always_comb begin
        eff    = (act_q == WIDTH'(1)) ? WIDTH'(2) : act_q;
        half   = ({1'b0, eff} + 1'b1) >> 1;
        wrap   = (cnt_q == eff - 1'b1);
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        out_d  = out_q;
        rise_d = rise_q;
        // Resync and a disabled channel both park the counter and take any pending divisor now.
        if (sync_all || act_q == '0) begin
            cnt_d  = '0;
            out_d  = 1'b0;
            rise_d = 1'b0;
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
        end else begin
            out_d  = ({1'b0, cnt_q} < half);
            rise_d = (cnt_q == '0);
            if (wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A write in the same cycle lands in the shadow after any apply above.
        if (wr) begin
            shd_d  = wr_data;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge in or negedge resetb) begin
        if (!resetb) begin
            cnt_q  <= '0;
            act_q  <= WIDTH'(DEFAULT_DIV);
            shd_q  <= WIDTH'(DEFAULT_DIV);
            pend_q <= 1'b0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            rise_q <= rise_d;
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign pending = pend_q;
endmodule

module clock_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6,
    parameter int SEL_W       = 3
) (
    input  logic              in,
    input  logic              resetb,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [WIDTH-1:0]  div_data,
    input  logic              sync_all,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] pending
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Selects at or above NUM_CH match no channel, so such writes are dropped.
        logic wr_hit;
        assign wr_hit = div_wr && (div_sel == SEL_W'(g));

        clock_div_ch #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .in      (in),
            .resetb  (resetb),
            .wr      (wr_hit),
            .wr_data (div_data),
            .sync_all(sync_all),
            .out     (out[g]),
            .rise    (rise[g]),
            .pending (pending[g])
        );
    end
endmodule
